priority_grant_ctrl: RTL and testbench
======================================

PRIORITY_GRANT_CTRL -- requirements
Module: priority_grant_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the serviced-event counter.
REQ-003 Parameter TIMEOUT_CYCLES, default 15, SHALL set the ack wait limit in cycles; it is used only when TIMEOUT_EN is defined.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 code  input  2  encoded index from the upstream priority encoder.
REQ-007 valid  input  1  upstream "any request present" flag; qualifies code.
REQ-008 ack  input  1  consumer acknowledge of the current grant.
REQ-009 irq_req  output  1  request pending toward the consumer.
REQ-010 irq_id  output  2  latched index of the pending request.
REQ-011 grant  output  4  one-hot form of irq_id; all zeros when irq_req=0.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 svc_count  output  CNT_W  number of acknowledged requests, saturating.
REQ-014 timeout  output  1  one-cycle pulse on an ack timeout; the port exists in all builds.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-016 IDLE: irq_req=0, grant=0, busy=0; valid=1 at an edge SHALL latch code into irq_id and move to REQ at that edge (irq_req=1 in the following cycle, one-cycle latency).
REQ-017 IDLE with valid=0 SHALL stay in IDLE; code SHALL be ignored.
REQ-018 REQ: irq_req=1, busy=1, grant=1<<irq_id; irq_id and grant SHALL remain stable; valid and code SHALL be ignored.
REQ-019 REQ with ack=1 at an edge SHALL move to DONE and increment svc_count by 1.
REQ-020 svc_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 DONE SHALL last exactly one cycle with irq_req=0, grant=0, busy=1, then return to IDLE; valid during DONE SHALL be ignored.
REQ-022 ack in IDLE or DONE SHALL have no effect.
REQ-023 irq_id SHALL retain its last value outside REQ.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and set irq_req=0, irq_id=0, grant=0, busy=0, svc_count=0, timeout=0, wait timer=0, from any state including mid-REQ.
REQ-025 On the first edge with rst=0 and valid=1, the block SHALL behave as in REQ-016.

Configuration
REQ-026 Macro TIMEOUT_EN, when defined, SHALL add a wait timer that clears on entry to REQ and increments each REQ cycle without ack.
REQ-027 With TIMEOUT_EN, when the timer reaches TIMEOUT_CYCLES without ack, the FSM SHALL move to DONE, pulse timeout for that one transition cycle, and leave svc_count unchanged.
REQ-028 With TIMEOUT_EN, an ack arriving in the same cycle as expiry SHALL win: normal completion, count increments, no timeout pulse.
REQ-029 Without TIMEOUT_EN, REQ SHALL wait indefinitely for ack, timeout SHALL be tied 0, and no timer logic SHALL exist.

Structure
REQ-030 A shared package/header prio_pkg SHALL hold the FSM state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and the 2-bit index width constant.
REQ-031 A sub-module dec2to4 SHALL implement the 2-to-4 one-hot decode with an enable; grant is its output, enabled by irq_req.

Verification
REQ-032 Reset, then valid=1 with code=2'b10 for one cycle -> next cycle irq_req=1, irq_id=2, grant=4'b0100, busy=1.
REQ-033 In REQ, drive code=2'b01 with valid=1, then ack=1 -> irq_id stays 2, then DONE for one cycle (grant=0, busy=1), IDLE next, svc_count=1.
REQ-034 CNT_W=2, four acknowledged requests -> svc_count reads 1, 2, 3, 3.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> exactly one timeout pulse after 15 REQ cycles, svc_count unchanged; a second run with ack on cycle 15 -> no pulse, count +1.
REQ-036 rst=1 while in REQ with svc_count=5 -> next cycle all outputs 0 and state IDLE; ack afterwards -> no effect.

Source files
------------

// File: rtl/priority_grant_ctrl_pkg.sv
// prio_pkg: shared definitions for priority_grant_ctrl.
//   IDX_W    - width of the encoded request index
//   GRANT_W  - width of the one-hot grant vector
//   state_t  - grant FSM state encoding
//   to_onehot - index to one-hot helper used by the grant decoder
package prio_pkg;

    localparam int IDX_W   = 2;
    localparam int GRANT_W = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [GRANT_W-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        return GRANT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/priority_grant_ctrl_if.sv
// priority_grant_ctrl_if: request/grant bundle between the upstream encoder,
// the consumer and priority_grant_ctrl.
//   code, valid   - encoded request and its qualifier from the encoder
//   ack           - consumer acknowledge
//   irq_req       - request pending toward the consumer
//   irq_id, grant - latched index and its one-hot form
//   busy          - controller not idle
//   svc_count     - saturating count of acknowledged requests
//   timeout       - one-cycle pulse on ack timeout
// Modports: master = environment side, slave = controller side.
interface priority_grant_ctrl_if #(
    parameter int CNT_W = 8
);
    import prio_pkg::*;

    logic [IDX_W-1:0]   code;
    logic               valid;
    logic               ack;
    logic               irq_req;
    logic [IDX_W-1:0]   irq_id;
    logic [GRANT_W-1:0] grant;
    logic               busy;
    logic [CNT_W-1:0]   svc_count;
    logic               timeout;

    modport master (
        output code, valid, ack,
        input  irq_req, irq_id, grant, busy, svc_count, timeout
    );

    modport slave (
        input  code, valid, ack,
        output irq_req, irq_id, grant, busy, svc_count, timeout
    );

endinterface

// File: rtl/priority_grant_ctrl_dec2to4.sv
// dec2to4: 2-to-4 one-hot decoder with enable.
//   en     - when low the output is all zeros
//   idx    - index to decode
//   onehot - 1 << idx when enabled
module dec2to4
    import prio_pkg::*;
(
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [GRANT_W-1:0] onehot
);

    assign onehot = en ? to_onehot(idx) : '0;

endmodule

// File: rtl/priority_grant_ctrl.sv
// priority_grant_ctrl: latches an encoded request, holds it toward the
// consumer until acknowledged, and counts serviced requests.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - priority_grant_ctrl_if.slave (code/valid/ack in, grant side out)
// Optional feature: define TIMEOUT_EN to abandon a request that has not been
// acknowledged within TIMEOUT_CYCLES REQ cycles (pulses timeout). Without it
// REQ waits indefinitely and timeout is tied low.
//
// state | meaning
// IDLE  | nothing pending; valid latches code and starts a request
// REQ   | irq_req high, grant held, waiting for ack
// DONE  | one-cycle completion gap before returning to IDLE
module priority_grant_ctrl
    import prio_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_grant_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic             irq_req_q;
    logic [IDX_W-1:0] irq_id_q;
    logic             busy_q;
    logic [CNT_W-1:0] svc_count_q;
    logic [GRANT_W-1:0] grant_w;

`ifdef TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    // Expiry is judged on the last permitted REQ cycle, so the timer counts
    // the REQ cycles already spent without ack.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;
    logic               timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            irq_req_q   <= 1'b0;
            irq_id_q    <= '0;
            busy_q      <= 1'b0;
            svc_count_q <= '0;
`ifdef TIMEOUT_EN
            timer       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        state     <= REQ;
                        irq_id_q  <= bus.code;
                        irq_req_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef TIMEOUT_EN
                        timer     <= '0;
`endif
                    end
                end
                REQ: begin
                    // ack takes precedence over a coincident expiry
                    if (bus.ack) begin
                        state     <= DONE;
                        irq_req_q <= 1'b0;
                        if (svc_count_q != CNT_MAX) begin
                            svc_count_q <= svc_count_q + 1'b1;
                        end
                    end
`ifdef TIMEOUT_EN
                    else if (timer == TIMER_LAST) begin
                        state     <= DONE;
                        irq_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    irq_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    dec2to4 u_dec (
        .en     (irq_req_q),
        .idx    (irq_id_q),
        .onehot (grant_w)
    );

    assign bus.irq_req   = irq_req_q;
    assign bus.irq_id    = irq_id_q;
    assign bus.grant     = grant_w;
    assign bus.busy      = busy_q;
    assign bus.svc_count = svc_count_q;
`ifdef TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_priority_grant_ctrl.sv
module tb_priority_grant_ctrl;
    import prio_pkg::*;

    localparam int TO_CYC = 15;

    typedef struct {
        int cnt;
        int cnt_sat;
        bit to;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priority_grant_ctrl_if #(.CNT_W(8)) bus ();
    priority_grant_ctrl_if #(.CNT_W(2)) bus_sat ();

    assign bus_sat.code  = bus.code;
    assign bus_sat.valid = bus.valid;
    assign bus_sat.ack   = bus.ack;

    priority_grant_ctrl #(.CNT_W(8), .TIMEOUT_CYCLES(TO_CYC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    priority_grant_ctrl #(.CNT_W(2), .TIMEOUT_CYCLES(TO_CYC)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    int    checks = 0;
    int    errors = 0;
    int    exp_count = 0;
    int    req_q[$];
    done_t done_q[$];
    bit    mon_en = 1'b0;
    logic  prev_req = 1'b0;
    int    cur_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations when the DUT presents a new request or a
    // completion cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.irq_req === 1'b1 && prev_req !== 1'b1) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got irq_id %0d expected no request", bus.irq_id);
                end else begin
                    cur_id = req_q.pop_front();
                    check("req_irq_id", 32'(bus.irq_id), cur_id);
                end
            end
            if (bus.irq_req === 1'b1) begin
                check("req_grant", 32'(bus.grant), 32'(1) << cur_id);
                check("req_busy", 32'(bus.busy), 1);
                check("req_id_stable", 32'(bus.irq_id), cur_id);
            end
            if (bus.busy === 1'b1 && bus.irq_req === 1'b0) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got svc_count %0d expected no completion", bus.svc_count);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_svc_count", 32'(bus.svc_count), d.cnt);
                    check("done_sat_count", 32'(bus_sat.svc_count), d.cnt_sat);
                    check("done_timeout", 32'(bus.timeout), 32'(d.to));
                    check("done_grant", 32'(bus.grant), 0);
                end
            end else begin
                check("stray_timeout", 32'(bus.timeout), 0);
            end
            prev_req = bus.irq_req;
        end
    end

    // One request: REQ lasts wait_cycles+1 cycles when acked, or wait_cycles
    // cycles when left to time out. valid/code toggle during REQ and valid/ack
    // are asserted in DONE and ack in the following IDLE cycle, all of which
    // must be ignored.
    task automatic issue(input logic [1:0] c, input int wait_cycles, input bit give_ack);
        done_t d;
        bus.valid = 1'b1;
        bus.code  = c;
        req_q.push_back(int'(c));
        if (give_ack) exp_count++;
        d.cnt     = (exp_count > 255) ? 255 : exp_count;
        d.cnt_sat = (exp_count > 3) ? 3 : exp_count;
        d.to      = !give_ack;
        done_q.push_back(d);
        @(posedge clk) #1;
        bus.code = ~c;
        @(negedge clk);
        check("req_latency", 32'(bus.irq_req), 1);
        repeat (wait_cycles) begin
            @(posedge clk) #1;
            bus.code = bus.code + 2'd1;
        end
        if (give_ack) begin
            bus.ack = 1'b1;
            @(posedge clk) #1;
        end
        bus.valid = 1'b1;
        bus.code  = ~c;
        bus.ack   = 1'b1;
        @(negedge clk);
        check("done_state_busy", 32'(bus.busy), 1);
        check("done_state_req", 32'(bus.irq_req), 0);
        @(posedge clk) #1;
        bus.valid = 1'b0;
        @(negedge clk);
        check("idle_req", 32'(bus.irq_req), 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_grant", 32'(bus.grant), 0);
        check("idle_irq_id", 32'(bus.irq_id), 32'(c));
        check("idle_svc_count", 32'(bus.svc_count), d.cnt);
        @(posedge clk) #1;
        bus.ack = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.code  = 2'd0;
        bus.ack   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_irq_req", 32'(bus.irq_req), 0);
        check("rst_irq_id", 32'(bus.irq_id), 0);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_svc_count", 32'(bus.svc_count), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        @(posedge clk) #1;
        rst = 1'b0;

        // first edge out of reset with valid high starts a request
        issue(2'd2, 3, 1'b1);

        // idle with valid low: code ignored, irq_id retained
        bus.code = 2'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_irq_req", 32'(bus.irq_req), 0);
        check("hold_irq_id", 32'(bus.irq_id), 2);
        @(posedge clk) #1;

        issue(2'd0, 0, 1'b1);
        issue(2'd3, 1, 1'b1);
        issue(2'd1, 5, 1'b1);
        issue(2'd2, 2, 1'b1);

        // reset in the middle of REQ with svc_count = 5
        check("pre_rst_count", 32'(bus.svc_count), 5);
        bus.valid = 1'b1;
        bus.code  = 2'd3;
        req_q.push_back(3);
        @(posedge clk) #1;
        bus.valid = 1'b0;
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst     = 1'b0;
        bus.ack = 1'b1;
        exp_count = 0;
        @(negedge clk);
        check("mid_rst_irq_req", 32'(bus.irq_req), 0);
        check("mid_rst_irq_id", 32'(bus.irq_id), 0);
        check("mid_rst_grant", 32'(bus.grant), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_svc_count", 32'(bus.svc_count), 0);
        check("mid_rst_sat_count", 32'(bus_sat.svc_count), 0);
        check("mid_rst_timeout", 32'(bus.timeout), 0);
        @(posedge clk) #1;
        bus.ack = 1'b0;
        @(negedge clk);
        check("ack_after_rst_count", 32'(bus.svc_count), 0);
        check("ack_after_rst_busy", 32'(bus.busy), 0);
        @(posedge clk) #1;

`ifdef TIMEOUT_EN
        issue(2'd1, TO_CYC, 1'b0);
        issue(2'd3, TO_CYC - 1, 1'b1);
`else
        issue(2'd1, 20, 1'b1);
`endif
        issue(2'd0, 0, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("req_q_drained", req_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
